invertor_oscillator_bank: RTL and testbench

Time-multiplexed bank of CHANNELS simplified CMOS invertor RC square-wave oscillators. Each channel has a runtime half-period in fractional samples and its own gate. The bank advances every channel once per audio sample and mixes the channels into one saturated signed audio word. It sits between the per-board discrete-sound control latches and the audio mixer, and is driven by the shared `audio_clk_en` sample strobe.

---
 rtl/invertor_oscillator_bank.sv | 217 +++++++++++++++++++++
 tb/tb_invertor_oscillator_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/invertor_oscillator_bank.sv
// invertor_oscillator_bank
// Time-multiplexed bank of CHANNELS simplified CMOS invertor RC square-wave
// oscillators. One audio_clk_en strobe starts a scan that advances each
// channel once (one channel per clk), then a single MIX cycle publishes the
// saturated sum on audio_out with a one-cycle sample_valid pulse.
//
// Optional build macro: INVERTOR_OSC_TRANSFER_EN
//   When defined, each channel contributes a one-pole filtered value y that
//   chases the hard +/-AMPLITUDE target, approximating the finite edge slope
//   of the invertor transfer. When undefined, contributions are hard squares.
//   The per-channel logic level on `out` is identical in both builds.
//
// Handshake: audio_clk_en is a one-cycle strobe with no back-pressure. A
// strobe seen while busy (SCAN or MIX) is dropped and sets sticky overrun.
// sample_valid is a one-cycle pulse coincident with the new audio_out value.
module invertor_oscillator_bank #(
    parameter int CHANNELS     = 4,
    parameter int AMPLITUDE    = 8191,
    parameter int OUT_WIDTH    = 16,
    parameter int HP_WIDTH     = 24,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           audio_clk_en,
    input  logic [CHANNELS-1:0]            gate,
    input  logic [CHANNELS*HP_WIDTH-1:0]   half_period,
    output logic [CHANNELS-1:0]            out,
    output logic [OUT_WIDTH-1:0]           audio_out,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [1:0]                     dbg_state
);

    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW  = OUT_WIDTH + $clog2(CHANNELS) + 1;
    localparam int HW1 = HP_WIDTH + 1;

    localparam logic [CW-1:0]          LAST_CH = CW'(CHANNELS - 1);
    localparam logic [HW1-1:0]         ONE_Q   = HW1'(32'h10000);
    localparam logic signed [SW-1:0]   SAT_MAX = SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0]   SAT_MIN = SW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_MIX  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_ch;
    logic [HP_WIDTH-1:0]     r_acc [CHANNELS];
    logic [CHANNELS-1:0]     r_level;
    logic signed [SW-1:0]    r_sum;
    logic [OUT_WIDTH-1:0]    r_audio_out;
    logic                    r_sample_valid;
    logic                    r_overrun;

    logic [HP_WIDTH-1:0]     w_hp_arr [CHANNELS];
    logic                    w_last;
    logic                    w_gate;
    logic [HP_WIDTH-1:0]     w_hp_raw;
    logic [HW1-1:0]          w_hp;
    logic [HW1-1:0]          w_a;
    logic [HW1-1:0]          w_a_sub;
    logic                    w_wrap;
    logic [HP_WIDTH-1:0]     w_acc_next;
    logic                    w_level_next;
    logic signed [SW-1:0]    w_contrib;
    logic signed [SW-1:0]    w_sum_next;
    logic [OUT_WIDTH-1:0]    w_sat;

    assign out          = r_level;
    assign audio_out    = r_audio_out;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != S_IDLE);
    assign overrun      = r_overrun;
    assign dbg_state    = r_state;
    assign w_last       = (r_state == S_SCAN) && (r_ch == LAST_CH);

    // Unpack the flat half-period bus into one word per channel.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            w_hp_arr[n] = half_period[n*HP_WIDTH +: HP_WIDTH];
        end
    end

    // Next-state logic: one pass IDLE -> SCAN (CHANNELS cycles) -> MIX -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (audio_clk_en) w_state_next = S_SCAN;
            S_SCAN:  if (r_ch == LAST_CH) w_state_next = S_MIX;
            S_MIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Oscillator step for the channel in the current slot; the half-period is
    // clamped to one sample so a channel toggles at most once per sample.
    always_comb begin
        w_gate     = gate[r_ch];
        w_hp_raw   = w_hp_arr[r_ch];
        w_hp       = ({1'b0, w_hp_raw} < ONE_Q) ? ONE_Q : {1'b0, w_hp_raw};
        w_a        = {1'b0, r_acc[r_ch]} + ONE_Q;
        w_wrap     = (w_a >= w_hp);
        w_a_sub    = w_a - w_hp;
        w_acc_next = '0;
        w_level_next = 1'b0;
        if (w_gate) begin
            w_acc_next   = w_wrap ? w_a_sub[HP_WIDTH-1:0] : w_a[HP_WIDTH-1:0];
            w_level_next = r_level[r_ch] ^ w_wrap;
        end
    end

`ifdef INVERTOR_OSC_TRANSFER_EN
    localparam int YW  = OUT_WIDTH + 1;
    localparam int YW1 = YW + 1;
    localparam logic signed [YW-1:0] AMP_Y = YW'(AMPLITUDE);

    logic signed [YW-1:0]  r_y [CHANNELS];
    logic signed [YW-1:0]  w_y_cur;
    logic signed [YW-1:0]  w_target;
    logic signed [YW1-1:0] w_diff;
    logic signed [YW1-1:0] w_step;
    logic signed [YW-1:0]  w_y_next;

    // One-pole smoothing of the channel toward its hard target; the filtered
    // value is what goes into the mix.
    always_comb begin
        w_y_cur  = r_y[r_ch];
        w_target = '0;
        if (w_gate) begin
            w_target = w_level_next ? AMP_Y : -AMP_Y;
        end
        w_diff    = YW1'(w_target) - YW1'(w_y_cur);
        w_step    = w_diff >>> SMOOTH_SHIFT;
        w_y_next  = w_y_cur + YW'(w_step);
        w_contrib = SW'(w_y_next);
    end

    // Filter state, one value per channel, written in its slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_y[n] <= '0;
            end
        end else if (r_state == S_SCAN) begin
            r_y[r_ch] <= w_y_next;
        end
    end
`else
    // Hard square contribution; a gated-off channel contributes nothing.
    always_comb begin
        w_contrib = '0;
        if (w_gate) begin
            w_contrib = w_level_next ? SW'(AMPLITUDE) : -SW'(AMPLITUDE);
        end
    end
`endif

    // Running sum including this slot, saturated to the signed output range.
    always_comb begin
        w_sum_next = r_sum + w_contrib;
        if (w_sum_next > SAT_MAX) begin
            w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (w_sum_next < SAT_MIN) begin
            w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            w_sat = w_sum_next[OUT_WIDTH-1:0];
        end
    end

    // Sequencer, slot counter, accumulation and published sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_ch           <= '0;
            r_sum          <= '0;
            r_audio_out    <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_sample_valid <= w_last;
            if (audio_clk_en && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_SCAN) begin
                r_ch  <= w_last ? '0 : r_ch + CW'(1);
                r_sum <= w_sum_next;
            end else begin
                r_ch  <= '0;
                r_sum <= '0;
            end
            if (w_last) begin
                r_audio_out <= w_sat;
            end
        end
    end

    // Per-channel phase accumulator and logic level, written in its slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_acc[n] <= '0;
            end
            r_level <= '0;
        end else if (r_state == S_SCAN) begin
            r_acc[r_ch]   <= w_acc_next;
            r_level[r_ch] <= w_level_next;
        end
    end

endmodule

// File: tb/tb_invertor_oscillator_bank.sv
// Directed bench for invertor_oscillator_bank. Three instances share clock,
// reset and strobe: A (2 channels, default amplitude), B (4 channels,
// amplitude 16383, saturation) and C (1 channel, SMOOTH_SHIFT=1, filter).
// Expected filtered values apply when INVERTOR_OSC_TRANSFER_EN is defined.
module tb_invertor_oscillator_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        strobe = 1'b0;

    logic [1:0]  gate_a = '0;
    logic [47:0] hp_a = '0;
    logic [1:0]  out_a;
    logic [15:0] audio_a;
    logic        valid_a, busy_a, overrun_a;
    logic [1:0]  dbg_a;

    logic [3:0]  gate_b = '0;
    logic [95:0] hp_b = '0;
    logic [3:0]  out_b;
    logic [15:0] audio_b;
    logic        valid_b, busy_b, overrun_b;
    logic [1:0]  dbg_b;

    logic [0:0]  gate_c = '0;
    logic [23:0] hp_c = '0;
    logic [0:0]  out_c;
    logic [15:0] audio_c;
    logic        valid_c, busy_c, overrun_c;
    logic [1:0]  dbg_c;

    int checks = 0;
    int failures = 0;

    // Clock.
    always #5 clk = ~clk;

    invertor_oscillator_bank #(.CHANNELS(2)) u_a (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(strobe),
        .gate(gate_a), .half_period(hp_a), .out(out_a), .audio_out(audio_a),
        .sample_valid(valid_a), .busy(busy_a), .overrun(overrun_a), .dbg_state(dbg_a)
    );

    invertor_oscillator_bank #(.CHANNELS(4), .AMPLITUDE(16383)) u_b (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(strobe),
        .gate(gate_b), .half_period(hp_b), .out(out_b), .audio_out(audio_b),
        .sample_valid(valid_b), .busy(busy_b), .overrun(overrun_b), .dbg_state(dbg_b)
    );

    invertor_oscillator_bank #(.CHANNELS(1), .SMOOTH_SHIFT(1)) u_c (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(strobe),
        .gate(gate_c), .half_period(hp_c), .out(out_c), .audio_out(audio_c),
        .sample_valid(valid_c), .busy(busy_c), .overrun(overrun_c), .dbg_state(dbg_c)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample: strobe high for `hold` cycles, then watch 8 falling edges
    // and check the valid pulse position of every instance and busy of A.
    task automatic run_sample(input int hold);
        int na, nb, nc, ka, kb, kc;
        logic bz [1:8];
        na = 0; nb = 0; nc = 0; ka = 0; kb = 0; kc = 0;
        strobe = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == hold) strobe = 1'b0;
            bz[k] = busy_a;
            if (valid_a) begin na++; ka = k; end
            if (valid_b) begin nb++; kb = k; end
            if (valid_c) begin nc++; kc = k; end
        end
        chk("a_valid_count", na, 1);
        chk("a_valid_cycle", ka, 3);
        chk("b_valid_count", nb, 1);
        chk("b_valid_cycle", kb, 5);
        chk("c_valid_count", nc, 1);
        chk("c_valid_cycle", kc, 2);
        chk("a_busy_t1", int'(bz[1]), 1);
        chk("a_busy_mix", int'(bz[3]), 1);
        chk("a_busy_done", int'(bz[4]), 0);
    endtask

    function automatic int sa(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    initial begin
        int lv1 [8];
        int lv2 [9];
        int lv3 [5];
        int nv;
        lv1 = '{0, 0, 1, 1, 1, 0, 0, 0};
        lv2 = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
        lv3 = '{1, 0, 1, 0, 1};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_out", int'(out_a), 0);
        chk("rst_audio", sa(audio_a), 0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_overrun", int'(overrun_a), 0);
        chk("rst_state", int'(dbg_a), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Half-period of three samples on channel 0; channel 1 gated off.
        gate_a = 2'b01;
        hp_a = {24'h000000, 24'h030000};
        for (int s = 0; s < 8; s++) begin
            run_sample(1);
            chk("t1_out0", int'(out_a[0]), lv1[s]);
            chk("t1_out1", int'(out_a[1]), 0);
`ifndef INVERTOR_OSC_TRANSFER_EN
            chk("t1_audio", sa(audio_a), (lv1[s] == 1) ? 8191 : -8191);
`endif
        end

        // Gate off clears, then fractional half-period of 1.5 samples.
        gate_a = 2'b00;
        run_sample(1);
        chk("t2_gateoff_out", int'(out_a), 0);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t2_gateoff_audio", sa(audio_a), 0);
`endif
        gate_a = 2'b01;
        hp_a = {24'h000000, 24'h018000};
        for (int s = 0; s < 9; s++) begin
            run_sample(1);
            chk("t2_frac_out0", int'(out_a[0]), lv2[s]);
        end

        // Half-period below one sample clamps: toggle every sample.
        gate_a = 2'b00;
        run_sample(1);
        gate_a = 2'b01;
        hp_a = '0;
        for (int s = 0; s < 5; s++) begin
            run_sample(1);
            chk("t3_clamp_out0", int'(out_a[0]), lv3[s]);
        end

        // Gate dropped while level is high.
        gate_a = 2'b00;
        run_sample(1);
        chk("t4_drop_out", int'(out_a), 0);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t4_drop_audio", sa(audio_a), 0);
`endif

        // Back-to-back strobe: second one dropped, overrun set, one toggle.
        chk("t5_overrun_before", int'(overrun_a), 0);
        gate_a = 2'b01;
        run_sample(2);
        chk("t5_overrun_after", int'(overrun_a), 1);
        chk("t5_single_toggle", int'(out_a), 1);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t5_audio", sa(audio_a), 8191);
`endif

        // Reset asserted mid-scan: everything clears, no valid pulse.
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_out", int'(out_a), 0);
        chk("t6_rst_audio", sa(audio_a), 0);
        chk("t6_rst_busy", int'(busy_a), 0);
        chk("t6_rst_valid", int'(valid_a), 0);
        chk("t6_rst_overrun", int'(overrun_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (valid_a) nv++;
        end
        chk("t6_no_valid", nv, 0);
        chk("t6_idle_state", int'(dbg_a), 0);
        gate_a = 2'b00;

        // Saturation with four channels of amplitude 16383.
        gate_b = 4'hf;
        hp_b = '0;
        run_sample(1);
        chk("t7_all_high_out", int'(out_b), 15);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t7_sat_pos", sa(audio_b), 32767);
`else
        chk("t7_filt_pos", sa(audio_b), 16380);
`endif
        run_sample(1);
        chk("t7_all_low_out", int'(out_b), 0);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t7_sat_neg", sa(audio_b), -32768);
`else
        chk("t7_filt_neg", sa(audio_b), -4100);
`endif
        gate_b = 4'h0;

        // Single channel driven high then held high.
        gate_c = 1'b1;
        hp_c = 24'h010000;
        run_sample(1);
        chk("t8_out_s1", int'(out_c), 1);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t8_audio_s1", sa(audio_c), 8191);
`else
        chk("t8_audio_s1", sa(audio_c), 4095);
`endif
        hp_c = 24'hffffff;
        run_sample(1);
        chk("t8_out_s2", int'(out_c), 1);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t8_audio_s2", sa(audio_c), 8191);
`else
        chk("t8_audio_s2", sa(audio_c), 6143);
`endif
        run_sample(1);
        chk("t8_out_s3", int'(out_c), 1);
`ifndef INVERTOR_OSC_TRANSFER_EN
        chk("t8_audio_s3", sa(audio_c), 8191);
`else
        chk("t8_audio_s3", sa(audio_c), 7167);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
